rmii_frame_rx: RTL and testbench

- Receive-side companion to the team's RMII frame transmitter.
- Consumes the 2-bit RMII receive stream at 50 MHz and strips the preamble and SFD.
- Forwards payload dibits on an axiov/axiod stream with the 4-byte FCS removed.
- Checks the Ethernet CRC-32 and reports a per-frame pass/fail pulse. Sits between the PHY RMII pins and the downstream packet parser.

---
 rtl/rmii_frame_rx.sv | 144 ++++++++++++++
 tb/tb_rmii_frame_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_rx.sv
// RMII receive framer: strips preamble/SFD, forwards payload dibits with the trailing FCS withheld,
// and checks the Ethernet CRC-32 residue at end of frame.
module rmii_frame_rx #(
    parameter int unsigned MIN_PREAMBLE = 8,
    parameter int unsigned FCS_DIBITS   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       frame_done,
    output logic       fcs_ok
);

    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam int unsigned LineW      = 2 * FCS_DIBITS;
    localparam logic [4:0]  MinPre     = 5'(MIN_PREAMBLE);
    localparam logic [15:0] FcsDib     = 16'(FCS_DIBITS);
    localparam logic [15:0] MinLen     = 16'(FCS_DIBITS + 4);

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

    state_e           state_q, state_d;
    logic [4:0]       pre_cnt_q, pre_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [15:0]      dib_cnt_q, dib_cnt_d;
    logic [LineW-1:0] line_q, line_d;
    logic             axiov_q, axiov_d;
    logic [1:0]       axiod_q, axiod_d;
    logic             frame_done_q, frame_done_d;
    logic             fcs_ok_q, fcs_ok_d;

    // Reflected CRC-32 update, rxd[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CrcPoly : 32'h0);
        end
        return c;
    endfunction

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        crc_d        = crc_q;
        dib_cnt_d    = dib_cnt_q;
        line_d       = line_q;
        axiov_d      = 1'b0;
        axiod_d      = 2'b00;
        frame_done_d = 1'b0;
        fcs_ok_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (crsdv) begin
                    if (rxd == 2'b01) begin
                        state_d   = StPreamble;
                        pre_cnt_d = 5'd1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPreamble: begin
                if (!crsdv) begin
                    state_d = StIdle;
                end else begin
                    case (rxd)
                        2'b01: begin
                            if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                        end
                        2'b11: begin
                            if (pre_cnt_q >= MinPre) begin
                                state_d   = StData;
                                crc_d     = 32'hFFFF_FFFF;
                                dib_cnt_d = 16'h0;
                                line_d    = '0;
                            end else begin
                                state_d = StDrop;
                            end
                        end
                        default: state_d = StDrop;
                    endcase
                end
            end
            StData: begin
                if (crsdv) begin
                    // Delay line holds back the last FCS_DIBITS dibits so the FCS is never emitted.
                    line_d = {line_q[LineW-3:0], rxd};
                    crc_d  = crc_dibit(crc_q, rxd);
                    if (dib_cnt_q != 16'hFFFF) dib_cnt_d = dib_cnt_q + 16'd1;
                    if (dib_cnt_q >= FcsDib) begin
                        axiov_d = 1'b1;
                        axiod_d = line_q[LineW-1 -: 2];
                    end
                end else begin
                    frame_done_d = 1'b1;
                    fcs_ok_d     = (crc_q == CrcResidue) && (dib_cnt_q[1:0] == 2'b00) &&
                                   (dib_cnt_q >= MinLen);
                    line_d       = '0;
                    state_d      = StIdle;
                end
            end
            StDrop: begin
                if (!crsdv) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pre_cnt_q    <= 5'd0;
            crc_q        <= 32'h0;
            dib_cnt_q    <= 16'h0;
            line_q       <= '0;
            axiov_q      <= 1'b0;
            axiod_q      <= 2'b00;
            frame_done_q <= 1'b0;
            fcs_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            crc_q        <= crc_d;
            dib_cnt_q    <= dib_cnt_d;
            line_q       <= line_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            frame_done_q <= frame_done_d;
            fcs_ok_q     <= fcs_ok_d;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign frame_done = frame_done_q;
    assign fcs_ok     = fcs_ok_q;

endmodule

// File: tb/tb_rmii_frame_rx.sv
// Directed bench for rmii_frame_rx: nominal, bad FCS, short preamble, runt, reset abort,
// unaligned tail and back-to-back frames.
module tb_rmii_frame_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       crsdv = 1'b0;
    logic [1:0] rxd   = 2'b00;
    logic       axiov;
    logic [1:0] axiod;
    logic       frame_done;
    logic       fcs_ok;

    rmii_frame_rx #(
        .MIN_PREAMBLE(8),
        .FCS_DIBITS  (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .crsdv     (crsdv),
        .rxd       (rxd),
        .axiov     (axiov),
        .axiod     (axiod),
        .frame_done(frame_done),
        .fcs_ok    (fcs_ok)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fcs_stray = 0;

    logic [1:0] rx_q[$];
    logic       done_q[$];
    logic [1:0] tx_q[$];

    // Payload 01 02 03 04 split into dibits, earliest first.
    logic [1:0] exp_pay[16] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                                2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [7:0] pay[4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    always @(negedge clk) begin
        if (rst_n) begin
            if (axiov) rx_q.push_back(axiod);
            if (frame_done) done_q.push_back(fcs_ok);
            else if (fcs_ok) fcs_stray++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-wise Ethernet CRC-32 of the payload, returned as the on-wire FCS value.
    function automatic logic [31:0] fcs_of_pay();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {24'h0, pay[b]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) tx_q.push_back(b[2*i +: 2]);
    endtask

    task automatic build_frame(input int npre, input logic [31:0] flip);
        logic [31:0] fcs;
        tx_q.delete();
        repeat (npre) tx_q.push_back(2'b01);
        tx_q.push_back(2'b11);
        for (int b = 0; b < 4; b++) add_byte(pay[b]);
        fcs = fcs_of_pay() ^ flip;
        for (int b = 0; b < 4; b++) add_byte(fcs[8*b +: 8]);
    endtask

    task automatic send(input int rst_at, input int gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clk);
            crsdv = 1'b1;
            rxd   = tx_q[i];
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_axiov", 32'(axiov), 32'd0);
                check("rst_done", 32'(frame_done), 32'd0);
                check("rst_fcs_ok", 32'(fcs_ok), 32'd0);
                rx_q.delete();
                done_q.delete();
            end else begin
                rst_n = 1'b1;
            end
        end
        repeat (gap) begin
            @(negedge clk);
            crsdv = 1'b0;
            rxd   = 2'b00;
            rst_n = 1'b1;
        end
    endtask

    task automatic chk_frame(input string tag, input int n_rx, input int n_chk, input int n_done,
                             input logic ok);
        check({tag, "_nrx"}, 32'(rx_q.size()), 32'(n_rx));
        for (int i = 0; i < n_chk && i < rx_q.size(); i++) begin
            check($sformatf("%s_d%0d", tag, i), 32'(rx_q[i]), 32'(exp_pay[i % 16]));
        end
        check({tag, "_ndone"}, 32'(done_q.size()), 32'(n_done));
        for (int i = 0; i < done_q.size(); i++) begin
            check($sformatf("%s_ok%0d", tag, i), 32'(done_q[i]), 32'(ok));
        end
        rx_q.delete();
        done_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_axiov", 32'(axiov), 32'd0);
        check("reset_axiod", 32'(axiod), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_fcs_ok", 32'(fcs_ok), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        build_frame(31, 32'h0);
        send(-1, 4);
        chk_frame("nominal", 16, 16, 1, 1'b1);

        build_frame(31, 32'h0000_0100);
        send(-1, 4);
        chk_frame("badfcs", 16, 16, 1, 1'b0);

        build_frame(4, 32'h0);
        send(-1, 4);
        chk_frame("shortpre", 0, 0, 0, 1'b0);
        build_frame(31, 32'h0);
        send(-1, 4);
        chk_frame("after_short", 16, 16, 1, 1'b1);

        tx_q.delete();
        repeat (31) tx_q.push_back(2'b01);
        tx_q.push_back(2'b11);
        for (int i = 0; i < 10; i++) tx_q.push_back(2'(i));
        send(-1, 4);
        chk_frame("runt", 0, 0, 1, 1'b0);

        build_frame(31, 32'h0);
        send(31 + 1 + 20, 4);
        chk_frame("aborted", 0, 0, 0, 1'b0);
        build_frame(31, 32'h0);
        send(-1, 4);
        chk_frame("after_rst", 16, 16, 1, 1'b1);

        build_frame(31, 32'h0);
        tx_q.push_back(2'b10);
        send(-1, 4);
        chk_frame("unaligned", 17, 16, 1, 1'b0);

        build_frame(31, 32'h0);
        send(-1, 1);
        send(-1, 4);
        chk_frame("b2b", 32, 32, 2, 1'b1);

        check("fcs_ok_outside_pulse", 32'(fcs_stray), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
